// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding, digit adjust constants and the digit-count sizing helper.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, REPORT} bcd_state_t;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

  // Decimal digits needed to represent 2^width-1.
  function automatic int max_digits(input int width);
    longint unsigned v;
    int d;
    v = (64'd1 << width) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble cell: adds 3 to a BCD digit of 5 or more, wrapping in 4 bits.
// Zero latency; no flow control.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH))
      adj = digit + BCD_DIGIT_W'(BCD_ADJ_ADD);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one adjust-and-shift step per clock; done WIDTH cycles after start.
// No backpressure: start is ignored mid-conversion, bcd holds the last result until the next done.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int DW  = BCD_DIGIT_W * DIGITS;
  localparam int SRW = DW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (DIGITS < max_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  bcd_state_t     state;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_adj;
  logic [SRW-1:0] sr_shift;
  logic [CW-1:0]  cnt;
  logic           last_step;

  // Shift register layout is {digits, binary}; only the digit field is adjusted.
  assign sr_adj[WIDTH-1:0] = sr[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit (sr[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .adj   (sr_adj[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  assign sr_shift  = sr_adj << 1;
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= {{DW{1'b0}}, bin};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          sr  <= sr_shift;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            bcd   <= sr_shift[SRW-1 -: DW];
            done  <= 1'b1;
            state <= REPORT;
          end
        end
        REPORT: begin
          done <= 1'b0;
          // A start seen on the report edge begins the next conversion directly,
          // giving one conversion per WIDTH+1 cycles when start is held.
          if (start) begin
            sr    <= {{DW{1'b0}}, bin};
            cnt   <= '0;
            state <= CONVERT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
